// File: rtl/irq_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_timer_pkg
//  Description : Shared types and helpers for the irq_timer_bank timer block.
//  Revision    : 1.0  initial release
// ============================================================================
package irq_timer_pkg;

    typedef enum logic {IDLE, RUN} tmr_state_t;

    typedef enum logic {PERIODIC, ONESHOT} tmr_mode_t;

    // Channel-index width; never zero so a single-channel bank still has a port.
    function automatic int ch_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_timer_channel.sv
`default_nettype none
// ============================================================================
//  Module      : irq_timer_channel
//  Description : One programmable interval timer with periodic/one-shot
//                modes, latched request, mask clear-hold and sticky overrun.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_timer_channel
    import irq_timer_pkg::*;
#(
    parameter int              CNT_W        = 24,
    parameter logic [CNT_W-1:0] RESET_PERIOD = '0,
    parameter logic            RESET_RUN    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic             cfg_enable,
    input  logic             ack,
    input  logic             mask,
    output logic             req_nxt,
    output logic             req,
    output logic             active,
    output logic             overrun
);

    tmr_state_t       state_q,  state_d;
    tmr_mode_t        mode_q,   mode_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             req_q,    req_d;
    logic             ovr_q,    ovr_d;
    logic             tick;
    logic             tick_eff;

    // Terminal count reached; a config write on the same cycle swallows it.
    assign tick     = (state_q == RUN) && (cnt_q == period_q);
    assign tick_eff = tick && !cfg_sel;

    // Next-state: config write wins, otherwise count / reload / stop.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        if (cfg_sel) begin
            period_d = cfg_period;
            mode_d   = cfg_oneshot ? ONESHOT : PERIODIC;
            cnt_d    = '0;
            state_d  = cfg_enable ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        cnt_d = '0;
                        if (mode_q == ONESHOT) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
        // Ack on a tick cycle keeps the request so the new event is not lost.
        req_d = !mask && (tick_eff || (req_q && !ack));
        ovr_d = !mask && !ack && (ovr_q || (tick_eff && req_q));
    end

    // State, counter and request latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RESET_RUN ? RUN : IDLE;
            mode_q   <= PERIODIC;
            cnt_q    <= '0;
            period_q <= RESET_PERIOD;
            req_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            req_q    <= req_d;
            ovr_q    <= ovr_d;
        end
    end

    assign req_nxt = req_d;
    assign req     = req_q;
    assign overrun = ovr_q;
    assign active  = (state_q == RUN);

endmodule
`default_nettype wire

// File: rtl/irq_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : irq_timer_bank
//  Description : Bank of N_CH interval timers producing latched interrupt
//                requests and a combined request for the MCU.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_timer_bank
    import irq_timer_pkg::*;
#(
    parameter int              N_CH          = 4,
    parameter int              CNT_W         = 24,
    parameter int unsigned     CLK_FREQUENCY = 50000000,
    parameter int unsigned     RESET_PERIOD  = CLK_FREQUENCY / 125 - 1,
    parameter logic [N_CH-1:0] RESET_ENABLE  = N_CH'(1),
    localparam int             CH_W          = ch_width(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic             cfg_enable,
    input  logic [N_CH-1:0]  ack,
    input  logic [N_CH-1:0]  mask,
    output logic [N_CH-1:0]  req,
    output logic             req_any,
    output logic [N_CH-1:0]  active,
    output logic [N_CH-1:0]  overrun
);

    logic [N_CH-1:0] sel;
    logic [N_CH-1:0] req_nxt;
    logic            req_any_q;

    // One-hot channel select; indices beyond N_CH match nothing.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            irq_timer_channel #(
                .CNT_W        (CNT_W),
                .RESET_PERIOD (CNT_W'(RESET_PERIOD)),
                .RESET_RUN    (RESET_ENABLE[g])
            ) u_ch (
                .clk         (clk),
                .reset       (reset),
                .cfg_sel     (sel[g]),
                .cfg_period  (cfg_period),
                .cfg_oneshot (cfg_oneshot),
                .cfg_enable  (cfg_enable),
                .ack         (ack[g]),
                .mask        (mask[g]),
                .req_nxt     (req_nxt[g]),
                .req         (req[g]),
                .active      (active[g]),
                .overrun     (overrun[g])
            );
        end
    endgenerate

    // Combined request registered from next-state so it lines up with req.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_any_q <= 1'b0;
        end else begin
            req_any_q <= |req_nxt;
        end
    end

    assign req_any = req_any_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_timer_bank
//  Description : Directed self-checking bench for irq_timer_bank.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_timer_bank;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_oneshot;
    logic             cfg_enable;
    logic [3:0]       ack, mask;
    logic [3:0]       req, active, overrun;
    logic             req_any;
    logic [2:0]       ack3, mask3;
    logic [2:0]       req3, active3, overrun3;
    logic             req_any3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_timer_bank #(
        .N_CH (4), .CNT_W (CNT_W), .CLK_FREQUENCY (1250),
        .RESET_PERIOD (9), .RESET_ENABLE (4'b0001)
    ) dut (
        .clk (clk), .reset (reset), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
        .cfg_period (cfg_period), .cfg_oneshot (cfg_oneshot),
        .cfg_enable (cfg_enable), .ack (ack), .mask (mask), .req (req),
        .req_any (req_any), .active (active), .overrun (overrun)
    );

    // Three-channel bank: index 3 fits in the 2-bit select but is out of range.
    irq_timer_bank #(
        .N_CH (3), .CNT_W (CNT_W), .CLK_FREQUENCY (1250),
        .RESET_PERIOD (9), .RESET_ENABLE (3'b001)
    ) dut3 (
        .clk (clk), .reset (reset), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
        .cfg_period (cfg_period), .cfg_oneshot (cfg_oneshot),
        .cfg_enable (cfg_enable), .ack (ack3), .mask (mask3), .req (req3),
        .req_any (req_any3), .active (active3), .overrun (overrun3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write lands on the next edge; returns just after that edge.
    task automatic cfg_write(input logic [1:0] ch, input logic [CNT_W-1:0] per,
                             input logic os, input logic en);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = per; cfg_oneshot = os; cfg_enable = en;
        step(1);
        cfg_we = 1'b0;
    endtask

    logic [3:0] seen;

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        cfg_oneshot = 1'b0; cfg_enable = 1'b0; ack = '0; mask = '0;
        ack3 = '0; mask3 = '0;
        step(3);
        reset = 1'b0;

        // Reset defaults: ch0 runs with period 9
        check_eq("rst_req",     req,     4'b0000);
        check_eq("rst_ovr",     overrun, 4'b0000);
        check_eq("rst_req_any", req_any, 1'b0);
        check_eq("rst_active",  active,  4'b0001);
        step(9);
        check_eq("rst_req_r9",  req,     4'b0000);
        step(1);
        check_eq("rst_req_r10", req,     4'b0001);
        check_eq("rst_any_r10", req_any, 1'b1);
        ack = 4'b0001; step(1); ack = '0;
        check_eq("ack_clear",   req,     4'b0000);
        step(8);
        check_eq("per_r19",     req,     4'b0000);
        step(1);
        check_eq("per_r20",     req,     4'b0001);
        ack = 4'b0001; cfg_write(2'd0, 8'd9, 1'b0, 1'b0); ack = '0;
        check_eq("stop_req",    req,     4'b0000);
        check_eq("stop_active", active,  4'b0000);

        // One-shot on ch2, period 5
        cfg_write(2'd2, 8'd5, 1'b1, 1'b1);
        check_eq("os_active",   active,  4'b0100);
        step(5);
        check_eq("os_req_k5",   req,     4'b0000);
        step(1);
        check_eq("os_req_k6",   req,     4'b0100);
        check_eq("os_idle_k6",  active,  4'b0000);
        ack = 4'b0100; step(1); ack = '0;
        check_eq("os_ack",      req,     4'b0000);
        seen = '0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            seen |= req;
        end
        check_eq("os_no_more",  seen,    4'b0000);

        // Ack/tick collision and overrun on ch0, period 3
        cfg_write(2'd0, 8'd3, 1'b0, 1'b1);
        step(4);
        check_eq("col_req_k4",  req,     4'b0001);
        step(3);
        ack = 4'b0001; step(1); ack = '0;
        check_eq("col_req_k8",  req,     4'b0001);
        check_eq("col_ovr_k8",  overrun, 4'b0000);
        step(4);
        check_eq("ovr_set_k12", overrun, 4'b0001);
        step(4);
        check_eq("ovr_hold_k16", overrun, 4'b0001);
        ack = 4'b0001; step(1); ack = '0;
        check_eq("ovr_clr",     overrun, 4'b0000);
        check_eq("ovr_clr_req", req,     4'b0000);
        cfg_write(2'd0, 8'd3, 1'b0, 1'b0);

        // Mask clear-hold on ch1, period 2
        mask = 4'b0010;
        cfg_write(2'd1, 8'd2, 1'b0, 1'b1);
        check_eq("mask_active", active,  4'b0010);
        seen = '0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            seen |= req;
        end
        check_eq("mask_held",   seen,    4'b0000);
        mask = '0;
        step(2);
        check_eq("unmask_k11",  req,     4'b0000);
        step(1);
        check_eq("unmask_k12",  req,     4'b0010);
        ack = 4'b0010; cfg_write(2'd1, 8'd2, 1'b0, 1'b0); ack = '0;
        check_eq("mask_stop",   req,     4'b0000);

        // Reconfigure mid-count: period 20 at cnt 15 rewritten to 4
        cfg_write(2'd0, 8'd20, 1'b0, 1'b1);
        step(15);
        cfg_write(2'd0, 8'd4, 1'b0, 1'b1);
        step(4);
        check_eq("recfg_w4",    req,     4'b0000);
        step(1);
        check_eq("recfg_w5",    req,     4'b0001);
        ack = 4'b0001; step(1); ack = '0;
        check_eq("recfg_ack",   req,     4'b0000);
        step(4);
        check_eq("recfg_w10",   req,     4'b0001);

        // Out-of-range index on the three-channel bank
        cfg_write(2'd3, 8'd2, 1'b0, 1'b1);
        check_eq("oor_active3", active3, 3'b001);
        check_eq("oor_active4", active,  4'b1001);
        step(5);
        check_eq("oor_hold3",   active3, 3'b001);

        // period 0 on all channels, then reset mid-operation
        cfg_write(2'd0, 8'd0, 1'b0, 1'b1);
        cfg_write(2'd1, 8'd0, 1'b0, 1'b1);
        cfg_write(2'd2, 8'd0, 1'b0, 1'b1);
        cfg_write(2'd3, 8'd0, 1'b0, 1'b1);
        step(3);
        check_eq("p0_req",      req,     4'b1111);
        check_eq("p0_ovr",      overrun, 4'b1111);
        reset = 1'b1; step(1); reset = 1'b0;
        check_eq("mid_rst_req", req,     4'b0000);
        check_eq("mid_rst_ovr", overrun, 4'b0000);
        check_eq("mid_rst_any", req_any, 1'b0);
        check_eq("mid_rst_act", active,  4'b0001);
        step(9);
        check_eq("mid_rst_r9",  req,     4'b0000);
        step(1);
        check_eq("mid_rst_r10", req,     4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
